// File: rtl/reg_writeback_arbiter_if.sv
// Writeback bundle between the irq/ALU/load sources, decode hazard queries and the register-file write port.
interface reg_writeback_arbiter_if #(
    parameter int REG_BITS = 5,
    parameter int BITS     = 16
);
    logic                irq_valid;
    logic [BITS-1:0]     irq_data;
    logic                irq_ready;
    logic                alu_valid;
    logic [REG_BITS-1:0] alu_reg;
    logic [BITS-1:0]     alu_data;
    logic                alu_ready;
    logic                load_valid;
    logic [REG_BITS-1:0] load_reg;
    logic [BITS-1:0]     load_data;
    logic                load_ready;
    logic [REG_BITS-1:0] query_reg_a;
    logic [REG_BITS-1:0] query_reg_b;
    logic                query_hit_a;
    logic                query_hit_b;
    logic [REG_BITS-1:0] regIn;
    logic [BITS-1:0]     regIn_data;

    modport master (
        output irq_valid, irq_data, alu_valid, alu_reg, alu_data,
               load_valid, load_reg, load_data, query_reg_a, query_reg_b,
        input  irq_ready, alu_ready, load_ready, query_hit_a, query_hit_b,
               regIn, regIn_data
    );

    modport slave (
        input  irq_valid, irq_data, alu_valid, alu_reg, alu_data,
               load_valid, load_reg, load_data, query_reg_a, query_reg_b,
        output irq_ready, alu_ready, load_ready, query_hit_a, query_hit_b,
               regIn, regIn_data
    );
endinterface

// File: rtl/reg_writeback_arbiter.sv
// Register-file write-port arbiter: irq > alu > buffered loads (loads force-granted after STARVE_MAX denials); 1-cycle grant-to-write,
// loads back-pressured by load_ready when the FIFO is full. WB_PERF_COUNT_EN adds load_stall_cnt/force_cnt counters.
module reg_writeback_arbiter #(
    parameter int REG_BITS   = 5,
    parameter int BITS       = 16,
    parameter int NULL_REG   = 31,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic                   CLK,
    input  logic                   RSTb,
    reg_writeback_arbiter_if.slave wb
`ifdef WB_PERF_COUNT_EN
    ,
    output logic [15:0]            load_stall_cnt,
    output logic [15:0]            force_cnt
`endif
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int ST_W  = $clog2(STARVE_MAX + 1);
    localparam logic [REG_BITS-1:0] IRQ_REG  = REG_BITS'(14);
    localparam logic [REG_BITS-1:0] NULL_IDX = REG_BITS'(NULL_REG);

    logic [REG_BITS-1:0] fifo_reg_q  [FIFO_DEPTH];
    logic [REG_BITS-1:0] fifo_reg_d  [FIFO_DEPTH];
    logic [BITS-1:0]     fifo_data_q [FIFO_DEPTH];
    logic [BITS-1:0]     fifo_data_d [FIFO_DEPTH];
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, q_idx;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [ST_W-1:0]     starve_q, starve_d;
    logic [REG_BITS-1:0] regin_q, regin_d;
    logic [BITS-1:0]     regin_data_q, regin_data_d;
    logic fifo_empty, fifo_full, force_gnt, irq_gnt, alu_gnt, fifo_gnt, push;
    logic hit_a, hit_b;

    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
        force_gnt  = !fifo_empty && (starve_q == ST_W'(STARVE_MAX));
        irq_gnt    = RSTb && !force_gnt && wb.irq_valid;
        alu_gnt    = RSTb && !force_gnt && !wb.irq_valid && wb.alu_valid;
        fifo_gnt   = RSTb && !fifo_empty && (force_gnt || (!wb.irq_valid && !wb.alu_valid));
        // A full FIFO still accepts when its head leaves in the same cycle.
        push       = RSTb && wb.load_valid && (!fifo_full || fifo_gnt);
    end

    assign wb.irq_ready   = irq_gnt;
    assign wb.alu_ready   = alu_gnt;
    assign wb.load_ready  = RSTb && (!fifo_full || fifo_gnt);
    assign wb.query_hit_a = hit_a;
    assign wb.query_hit_b = hit_b;
    assign wb.regIn       = regin_q;
    assign wb.regIn_data  = regin_data_q;

    always_comb begin
        regin_d      = NULL_IDX;
        regin_data_d = '0;
        if (irq_gnt) begin
            regin_d      = IRQ_REG;
            regin_data_d = wb.irq_data;
        end else if (alu_gnt) begin
            regin_d      = wb.alu_reg;
            regin_data_d = wb.alu_data;
        end else if (fifo_gnt) begin
            regin_d      = fifo_reg_q[rd_ptr_q];
            regin_data_d = fifo_data_q[rd_ptr_q];
        end

        fifo_reg_d  = fifo_reg_q;
        fifo_data_d = fifo_data_q;
        if (push) begin
            fifo_reg_d[wr_ptr_q]  = wb.load_reg;
            fifo_data_d[wr_ptr_q] = wb.load_data;
        end
        rd_ptr_d = rd_ptr_q + PTR_W'(fifo_gnt);
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        count_d  = count_q + CNT_W'(push) - CNT_W'(fifo_gnt);

        if (fifo_empty || fifo_gnt)
            starve_d = '0;
        else if (starve_q != ST_W'(STARVE_MAX))
            starve_d = starve_q + ST_W'(1);
        else
            starve_d = starve_q;
    end

    // The entry popped this cycle is covered by the register-file bypass, so it no longer counts as pending.
    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        q_idx = rd_ptr_q;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            q_idx = rd_ptr_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && !((i == 0) && fifo_gnt)) begin
                if (fifo_reg_q[q_idx] == wb.query_reg_a) hit_a = 1'b1;
                if (fifo_reg_q[q_idx] == wb.query_reg_b) hit_b = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            starve_q     <= '0;
            regin_q      <= NULL_IDX;
            regin_data_q <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            starve_q     <= starve_d;
            regin_q      <= regin_d;
            regin_data_q <= regin_data_d;
        end
    end

    always_ff @(posedge CLK) begin
        fifo_reg_q  <= fifo_reg_d;
        fifo_data_q <= fifo_data_d;
    end

`ifdef WB_PERF_COUNT_EN
    logic [15:0] load_stall_q, load_stall_d, force_q, force_d;

    always_comb begin
        load_stall_d = load_stall_q;
        force_d      = force_q;
        if (!fifo_empty && !fifo_gnt && (load_stall_q != 16'hFFFF))
            load_stall_d = load_stall_q + 16'd1;
        if (force_gnt && RSTb && (force_q != 16'hFFFF))
            force_d = force_q + 16'd1;
    end

    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            load_stall_q <= '0;
            force_q      <= '0;
        end else begin
            load_stall_q <= load_stall_d;
            force_q      <= force_d;
        end
    end

    assign load_stall_cnt = load_stall_q;
    assign force_cnt      = force_q;
`endif
endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Directed bench for reg_writeback_arbiter: expected register writes are queued as stimulus is driven and
// matched in order against every non-null write the DUT produces.
module tb_reg_writeback_arbiter;
    localparam int RB = 5;
    localparam int DB = 16;

    logic CLK  = 1'b0;
    logic RSTb = 1'b0;
    always #5 CLK = ~CLK;

    reg_writeback_arbiter_if #(.REG_BITS(RB), .BITS(DB)) wb ();

`ifdef WB_PERF_COUNT_EN
    logic [15:0] load_stall_cnt, force_cnt;
`endif

    reg_writeback_arbiter #(
        .REG_BITS(RB), .BITS(DB), .NULL_REG(31), .FIFO_DEPTH(2), .STARVE_MAX(3)
    ) dut (
        .CLK (CLK),
        .RSTb(RSTb),
        .wb  (wb)
`ifdef WB_PERF_COUNT_EN
        ,
        .load_stall_cnt(load_stall_cnt),
        .force_cnt     (force_cnt)
`endif
    );

    int errors = 0;
    int checks = 0;
    logic [RB+DB-1:0] sb [$];
    logic [RB+DB-1:0] exp_e;
    bit mon_en = 1'b0;
    int irq_pulses = 0;
    int alu_pulses = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [RB-1:0] r, input logic [DB-1:0] d);
        sb.push_back({r, d});
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Every write to a non-scratch register must match the next queued expectation.
    always @(negedge CLK) begin
        if (mon_en) begin
            irq_pulses += int'(wb.irq_ready);
            alu_pulses += int'(wb.alu_ready);
            if (wb.regIn != 5'd31) begin
                if (sb.size() == 0) begin
                    chk("unexpected_wr", 32'(wb.regIn), 32'd31);
                end else begin
                    exp_e = sb.pop_front();
                    chk("wr_reg", 32'(wb.regIn), 32'(exp_e[RB+DB-1:DB]));
                    chk("wr_data", 32'(wb.regIn_data), 32'(exp_e[DB-1:0]));
                end
            end
        end
    end

    initial begin
        // Reset with every valid asserted.
        wb.irq_valid = 1'b1;  wb.irq_data = 16'h5555;
        wb.alu_valid = 1'b1;  wb.alu_reg = 5'd4;  wb.alu_data = 16'h6666;
        wb.load_valid = 1'b1; wb.load_reg = 5'd5; wb.load_data = 16'h7777;
        wb.query_reg_a = 5'd5; wb.query_reg_b = 5'd4;
        RSTb = 1'b0;
        mon_en = 1'b1;
        tick();
        tick();
        chk("rst_regIn", 32'(wb.regIn), 32'd31);
        chk("rst_regIn_data", 32'(wb.regIn_data), 32'd0);
        chk("rst_irq_ready", 32'(wb.irq_ready), 32'd0);
        chk("rst_alu_ready", 32'(wb.alu_ready), 32'd0);
        chk("rst_load_ready", 32'(wb.load_ready), 32'd0);
        chk("rst_hit_a", 32'(wb.query_hit_a), 32'd0);
        chk("rst_hit_b", 32'(wb.query_hit_b), 32'd0);
        wb.irq_valid = 1'b0; wb.alu_valid = 1'b0; wb.load_valid = 1'b0;
        RSTb = 1'b1;
        tick();

        // Single load: buffered at edge N, written at edge N+1.
        wb.load_valid = 1'b1; wb.load_reg = 5'd5; wb.load_data = 16'hBEEF;
        wb.query_reg_a = 5'd5; wb.query_reg_b = 5'd6;
        #1;
        chk("ld_ready", 32'(wb.load_ready), 32'd1);
        chk("ld_hit_push_excl", 32'(wb.query_hit_a), 32'd0);
        expect_wr(5'd5, 16'hBEEF);
        tick();
        wb.load_valid = 1'b0;
        #1;
        chk("ld_not_early", 32'(wb.regIn), 32'd31);
        tick();
        chk("ld_wr_reg", 32'(wb.regIn), 32'd5);
        chk("ld_wr_data", 32'(wb.regIn_data), 32'hBEEF);
        tick();
        chk("ld_null_reg", 32'(wb.regIn), 32'd31);
        chk("ld_null_data", 32'(wb.regIn_data), 32'd0);

        // Priority: irq, then alu, then the buffered load.
        irq_pulses = 0; alu_pulses = 0;
        wb.irq_valid = 1'b1; wb.irq_data = 16'h1234;
        wb.alu_valid = 1'b1; wb.alu_reg = 5'd3; wb.alu_data = 16'h0042;
        wb.load_valid = 1'b1; wb.load_reg = 5'd9; wb.load_data = 16'h0909;
        wb.query_reg_a = 5'd9;
        #1;
        chk("pri_irq_ready", 32'(wb.irq_ready), 32'd1);
        chk("pri_alu_wait", 32'(wb.alu_ready), 32'd0);
        chk("pri_load_ready", 32'(wb.load_ready), 32'd1);
        expect_wr(5'd14, 16'h1234);
        expect_wr(5'd3, 16'h0042);
        expect_wr(5'd9, 16'h0909);
        tick();
        wb.irq_valid = 1'b0; wb.load_valid = 1'b0;
        #1;
        chk("pri_irq_first", 32'(wb.regIn), 32'd14);
        chk("pri_alu_ready", 32'(wb.alu_ready), 32'd1);
        chk("pri_hit_pending", 32'(wb.query_hit_a), 32'd1);
        tick();
        wb.alu_valid = 1'b0;
        #1;
        chk("pri_alu_second", 32'(wb.regIn), 32'd3);
        chk("pri_load_slot_alu", 32'(wb.alu_ready), 32'd0);
        tick();
        chk("pri_load_third", 32'(wb.regIn), 32'd9);
        tick();
        chk("pri_irq_pulses", 32'(irq_pulses), 32'd1);
        chk("pri_alu_pulses", 32'(alu_pulses), 32'd1);

        // Starvation: continuous ALU traffic, load to R7 forced through.
        wb.alu_valid = 1'b1; wb.alu_reg = 5'd2; wb.alu_data = 16'h1000;
        wb.load_valid = 1'b1; wb.load_reg = 5'd7; wb.load_data = 16'h0777;
        wb.query_reg_a = 5'd7;
        #1;
        chk("stv_alu_first", 32'(wb.alu_ready), 32'd1);
        expect_wr(5'd2, 16'h1000);
        tick();
        wb.load_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            wb.alu_data = 16'h1000 + 16'(k);
            #1;
            chk("stv_alu_gnt", 32'(wb.alu_ready), 32'd1);
            chk("stv_hit", 32'(wb.query_hit_a), 32'd1);
            expect_wr(5'd2, 16'h1000 + 16'(k));
            tick();
        end
        wb.alu_data = 16'h1004;
        #1;
        chk("stv_force_alu_denied", 32'(wb.alu_ready), 32'd0);
        chk("stv_force_hit_excl", 32'(wb.query_hit_a), 32'd0);
        expect_wr(5'd7, 16'h0777);
        tick();
        #1;
        chk("stv_forced_reg", 32'(wb.regIn), 32'd7);
        chk("stv_alu_resume", 32'(wb.alu_ready), 32'd1);
        expect_wr(5'd2, 16'h1004);
        tick();
        wb.alu_valid = 1'b0;
        tick();

        // Full FIFO: push and pop together on the force cycle.
        wb.alu_valid = 1'b1; wb.alu_reg = 5'd2; wb.alu_data = 16'h2000;
        wb.load_valid = 1'b1; wb.load_reg = 5'd10; wb.load_data = 16'hA0A0;
        #1;
        chk("full_alu_first", 32'(wb.alu_ready), 32'd1);
        expect_wr(5'd2, 16'h2000);
        tick();
        wb.alu_data = 16'h2001; wb.load_reg = 5'd11; wb.load_data = 16'hB0B0;
        #1;
        chk("full_ld_ready_1", 32'(wb.load_ready), 32'd1);
        expect_wr(5'd2, 16'h2001);
        tick();
        wb.alu_data = 16'h2002; wb.load_reg = 5'd12; wb.load_data = 16'hC0C0;
        #1;
        chk("full_ld_ready_0", 32'(wb.load_ready), 32'd0);
        expect_wr(5'd2, 16'h2002);
        tick();
        wb.alu_data = 16'h2003;
        #1;
        chk("full_ld_ready_0b", 32'(wb.load_ready), 32'd0);
        expect_wr(5'd2, 16'h2003);
        tick();
        #1;
        chk("full_force_ld_ready", 32'(wb.load_ready), 32'd1);
        chk("full_force_alu_denied", 32'(wb.alu_ready), 32'd0);
        expect_wr(5'd10, 16'hA0A0);
        tick();
        wb.load_valid = 1'b0;
        #1;
        chk("full_after_swap", 32'(wb.load_ready), 32'd0);
        chk("full_alu_resume", 32'(wb.alu_ready), 32'd1);
        expect_wr(5'd2, 16'h2003);
        tick();
        wb.alu_valid = 1'b0;
        expect_wr(5'd11, 16'hB0B0);
        expect_wr(5'd12, 16'hC0C0);
        tick();
        tick();
        tick();

        // Reset mid-operation drops both buffered loads and the pending ALU grant.
        wb.alu_valid = 1'b1; wb.alu_reg = 5'd2; wb.alu_data = 16'h3000;
        wb.load_valid = 1'b1; wb.load_reg = 5'd10; wb.load_data = 16'h1111;
        wb.query_reg_a = 5'd10; wb.query_reg_b = 5'd11;
        #1;
        expect_wr(5'd2, 16'h3000);
        tick();
        wb.alu_data = 16'h3001; wb.load_reg = 5'd11; wb.load_data = 16'h2222;
        #1;
        expect_wr(5'd2, 16'h3001);
        tick();
        wb.load_valid = 1'b0; wb.alu_data = 16'h3002;
        RSTb = 1'b0;
        #1;
        chk("mrst_alu_ready", 32'(wb.alu_ready), 32'd0);
        tick();
        RSTb = 1'b1; wb.alu_valid = 1'b0;
        #1;
        chk("mrst_regIn", 32'(wb.regIn), 32'd31);
        chk("mrst_hit_a", 32'(wb.query_hit_a), 32'd0);
        chk("mrst_hit_b", 32'(wb.query_hit_b), 32'd0);
        chk("mrst_load_ready", 32'(wb.load_ready), 32'd1);
        for (int k = 0; k < 4; k++) tick();
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
